// File: rtl/quadrature_decoder.sv
// quadrature_decoder: synchronised, glitch-filtered A/B quadrature decoder with wrapping position counter
module quadrature_decoder #(
  parameter int WIDTH      = 8,
  parameter int FILTER_LEN = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] pos_out,
  output logic             step_pulse,
  output logic             dir_out,
  output logic             err_out
);
  logic [1:0] s1_q, s2_q, prev_q, filt_q, filt_d, vld_q, diff;
  logic [3:0] cnt_q, cnt_d, run;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic primed_q, prime, accept, up, dn, bad, step_q, dir_q, dir_d, err_q, err_d;
  // vld_q marks when s2 first holds a real sample, so priming sees the actual encoder state
  always_comb begin
    run    = (s2_q == prev_q) ? cnt_q + 4'd1 : 4'd0;
    prime  = vld_q[1] && !primed_q;
    accept = primed_q && (s2_q != filt_q) && (run == 4'(FILTER_LEN - 1));
    cnt_d  = (!primed_q || s2_q == filt_q || accept) ? 4'd0 : run;
    diff   = {s2_q[1], ^s2_q} - {filt_q[1], ^filt_q};
    up     = accept && diff == 2'd1;
    dn     = accept && diff == 2'd3;
    bad    = accept && diff == 2'd2;
    filt_d = (prime || accept) ? s2_q : filt_q;
    pos_d  = load_en ? data_in : up ? pos_q + WIDTH'(1) : dn ? pos_q - WIDTH'(1) : pos_q;
    dir_d  = up ? 1'b1 : dn ? 1'b0 : dir_q;
    err_d  = bad || (err_q && !clear_err);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      vld_q    <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
      pos_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= {a_in, b_in};
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      vld_q    <= {vld_q[0], 1'b1};
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      primed_q <= primed_q || vld_q[1];
      pos_q    <= pos_d;
      step_q   <= up || dn;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end
  assign pos_out    = pos_q;
  assign step_pulse = step_q;
  assign dir_out    = dir_q;
  assign err_out    = err_q;
endmodule
